// File: rtl/smaqa_iter_unit_pkg.sv
// Shared types and constants for the iterative SMAQA functional unit.
package smaqa_iter_unit_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned PROD_W        = 2 * BYTE_W;
   localparam int unsigned NUM_LANES     = XLEN / BYTE_W;
   localparam int unsigned LANE_IDX_W    = 2;

   // Subset of the core configuration this unit depends on.
   typedef struct packed {
      int unsigned xlen;
   } cva6_cfg_t;

   localparam cva6_cfg_t CVA6_CFG = '{xlen: 32};

   // Functional-unit operations visible on the issue port.
   typedef enum logic [3:0] {
      ADD   = 4'd0,
      SUB   = 4'd1,
      MUL   = 4'd2,
      SMAQA = 4'd3
   } fu_op;

   typedef enum logic [1:0] {
      SMAQA_IDLE = 2'd0,
      SMAQA_BUSY = 2'd1,
      SMAQA_DONE = 2'd2
   } smaqa_state_e;

   // Operands and id captured at accept time.
   typedef struct packed {
      logic [XLEN-1:0]          a;
      logic [XLEN-1:0]          b;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } smaqa_req_t;

   // Select signed byte lane idx of a packed word.
   function automatic logic [BYTE_W-1:0] lane_byte(input logic [XLEN-1:0]       w,
                                                   input logic [LANE_IDX_W-1:0] idx);
      logic [BYTE_W-1:0] r;
      case (idx)
         2'd0:    r = w[7:0];
         2'd1:    r = w[15:8];
         2'd2:    r = w[23:16];
         default: r = w[31:24];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/smaqa_iter_unit_lane_mac.sv
// One SMAQA lane: signed 8x8 multiply, sign-extend, add to accumulator.
module smaqa_lane_mac
   import smaqa_iter_unit_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic [XLEN-1:0]   acc_i,
   output logic [XLEN-1:0]   acc_o
);

   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;
   logic signed [PROD_W-1:0] prod;

   // Both bytes widened to the product width so the product cannot overflow.
   always_comb begin
      a_ext = {{BYTE_W{a_i[BYTE_W-1]}}, a_i};
      b_ext = {{BYTE_W{b_i[BYTE_W-1]}}, b_i};
      prod  = a_ext * b_ext;
      acc_o = acc_i + {{(XLEN-PROD_W){prod[PROD_W-1]}}, prod};
   end

endmodule

// File: rtl/smaqa_iter_unit.sv
// Iterative SMAQA unit: rd + sum of four signed byte products, one lane per cycle.
module smaqa_iter_unit
   import smaqa_iter_unit_pkg::*;
#(
   parameter cva6_cfg_t CVA6Cfg = CVA6_CFG
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   input  logic                     valid_i,
   input  fu_op                     operation_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   input  logic [XLEN-1:0]          operand_c_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o
);

   if (CVA6Cfg.xlen != 32) begin : gen_xlen_chk
      $error("smaqa_iter_unit supports XLEN == 32 only");
   end

   smaqa_state_e             state_q, state_d;
   smaqa_req_t               req_q, req_d;
   logic [XLEN-1:0]          acc_q, acc_d;
   logic [LANE_IDX_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]          res_q, res_d;
   logic [TRANS_ID_BITS-1:0] tid_q, tid_d;

   logic                     accept;
   logic                     last_lane;
   logic [XLEN-1:0]          mac_acc;

   // Handshake: busy or flushing blocks new requests; flush masks a pending result.
   assign ready_o   = (state_q != SMAQA_BUSY) && !flush_i;
   assign accept    = valid_i && ready_o && (operation_i == SMAQA);
   assign valid_o   = (state_q == SMAQA_DONE) && !flush_i;
   assign last_lane = (cnt_q == LANE_IDX_W'(NUM_LANES - 1));
   assign result_o  = res_q;
   assign trans_id_o = tid_q;

   smaqa_lane_mac i_lane_mac (
      .a_i   (lane_byte(req_q.a, cnt_q)),
      .b_i   (lane_byte(req_q.b, cnt_q)),
      .acc_i (acc_q),
      .acc_o (mac_acc)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      tid_d   = tid_q;

      case (state_q)
         SMAQA_IDLE: begin
            if (accept) state_d = SMAQA_BUSY;
         end
         SMAQA_BUSY: begin
            if (flush_i) begin
               state_d = SMAQA_IDLE;
            end else begin
               acc_d = mac_acc;
               cnt_d = cnt_q + LANE_IDX_W'(1);
               if (last_lane) begin
                  state_d = SMAQA_DONE;
                  res_d   = mac_acc;
                  tid_d   = req_q.trans_id;
               end
            end
         end
         SMAQA_DONE: begin
            state_d = accept ? SMAQA_BUSY : SMAQA_IDLE;
         end
         default: state_d = SMAQA_IDLE;
      endcase

      if (accept) begin
         req_d.a        = operand_a_i;
         req_d.b        = operand_b_i;
         req_d.trans_id = trans_id_i;
         acc_d          = operand_c_i;
         cnt_d          = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= SMAQA_IDLE;
         req_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         tid_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         tid_q   <= tid_d;
      end
   end

endmodule

// File: tb/tb_smaqa_iter_unit.sv
// Self-checking bench for smaqa_iter_unit against an arithmetic reference.
module tb_smaqa_iter_unit;
   import smaqa_iter_unit_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     flush = 1'b0;
   logic                     valid = 1'b0;
   logic [TRANS_ID_BITS-1:0] tid_in = '0;
   fu_op                     op = ADD;
   logic [31:0]              opa = '0, opb = '0, opc = '0;
   logic                     ready, vout;
   logic [31:0]              res;
   logic [TRANS_ID_BITS-1:0] tid_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   smaqa_iter_unit dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .trans_id_i  (tid_in),
      .valid_i     (valid),
      .operation_i (op),
      .operand_a_i (opa),
      .operand_b_i (opb),
      .operand_c_i (opc),
      .ready_o     (ready),
      .valid_o     (vout),
      .result_o    (res),
      .trans_id_o  (tid_out)
   );

   // rd + sum of signed byte products, wrapping in 32-bit int.
   function automatic logic [31:0] ref_smaqa(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
      int acc;
      logic [31:0] wa, wb;
      logic signed [7:0] xa, xb;
      acc = int'(c);
      wa  = a;
      wb  = b;
      for (int i = 0; i < 4; i++) begin
         xa  = wa[i*8 +: 8];
         xb  = wb[i*8 +: 8];
         acc = acc + int'(xa) * int'(xb);
      end
      return 32'(acc);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Present one request from a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [TRANS_ID_BITS-1:0] id);
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(ready), 32'd1);
      valid  = 1'b1;
      op     = SMAQA;
      opa    = a;
      opb    = b;
      opc    = c;
      tid_in = id;
      @(negedge clk);
      valid  = 1'b0;
      opa    = $urandom;
      opb    = $urandom;
      opc    = $urandom;
   endtask

   // Four busy cycles, then the one-cycle result; returns in the result cycle.
   task automatic expect_result(input string tag, input logic [31:0] exp,
                                input logic [TRANS_ID_BITS-1:0] id);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy_valid"}, 32'(vout), 32'd0);
         check({tag, "_busy_ready"}, 32'(ready), 32'd0);
         @(negedge clk);
      end
      check({tag, "_valid"}, 32'(vout), 32'd1);
      check({tag, "_result"}, res, exp);
      check({tag, "_tid"}, 32'(tid_out), 32'(id));
   endtask

   task automatic quiet(input string tag, input int n);
      int hits = 0;
      repeat (n) begin
         @(negedge clk);
         if (vout) hits++;
      end
      check(tag, 32'(hits), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, c, held;
      logic [TRANS_ID_BITS-1:0] id;

      repeat (3) @(negedge clk);
      check("rst_valid", 32'(vout), 32'd0);
      check("rst_result", res, 32'd0);
      check("rst_tid", 32'(tid_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);

      // Reference vectors.
      send(32'h01020304, 32'h05060708, 32'h00000009, 3'd3);
      expect_result("vec_basic", 32'h0000004F, 3'd3);
      @(negedge clk);
      check("pulse_end", 32'(vout), 32'd0);
      check("hold_result", res, 32'h0000004F);
      send(32'hFFFFFFFF, 32'h01010101, 32'h0, 3'd1);
      expect_result("vec_neg", 32'hFFFFFFFC, 3'd1);
      @(negedge clk);
      send(32'h80808080, 32'h80808080, 32'h0, 3'd2);
      expect_result("vec_min", 32'h00010000, 3'd2);
      @(negedge clk);
      send(32'h00000001, 32'h00000001, 32'h7FFFFFFF, 3'd4);
      expect_result("vec_wrap", 32'h80000000, 3'd4);

      // Back-to-back: second request accepted in the DONE cycle.
      @(negedge clk);
      send(32'h11223344, 32'hF0E0D0C0, 32'h12345678, 3'd6);
      expect_result("b2b_first", ref_smaqa(32'h11223344, 32'hF0E0D0C0, 32'h12345678), 3'd6);
      send(32'h7F7F7F7F, 32'h81818181, 32'hDEADBEEF, 3'd5);
      expect_result("b2b_second", ref_smaqa(32'h7F7F7F7F, 32'h81818181, 32'hDEADBEEF), 3'd5);
      held = res;
      @(negedge clk);

      // Flush during BUSY kills the operation.
      send(32'h01010101, 32'h02020202, 32'h0, 3'd1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_ready_low", 32'(ready), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_to_idle", 32'(ready), 32'd1);
      quiet("flush_no_valid", 8);
      check("flush_hold_result", res, held);

      // Request presented during flush is not accepted.
      flush = 1'b1;
      valid = 1'b1;
      op    = SMAQA;
      @(negedge clk);
      valid = 1'b0;
      flush = 1'b0;
      #1;
      check("flush_req_dropped", 32'(ready), 32'd1);
      quiet("flush_req_quiet", 8);
      send(32'h05FB0A80, 32'hFF03C07F, 32'h00000100, 3'd7);
      expect_result("after_flush", ref_smaqa(32'h05FB0A80, 32'hFF03C07F, 32'h00000100), 3'd7);

      // Flush in DONE gates the result pulse combinationally.
      @(negedge clk);
      send(32'h0A0B0C0D, 32'h01020304, 32'h0, 3'd2);
      expect_result("done_pre", ref_smaqa(32'h0A0B0C0D, 32'h01020304, 32'h0), 3'd2);
      flush = 1'b1;
      #1;
      check("flush_gate_valid", 32'(vout), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_done_idle", 32'(ready), 32'd1);
      quiet("flush_done_quiet", 6);

      // Reset in the middle of BUSY.
      send(32'h12121212, 32'h34343434, 32'h1, 3'd3);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(vout), 32'd0);
      check("midrst_result", res, 32'd0);
      check("midrst_tid", 32'(tid_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(ready), 32'd1);
      quiet("midrst_quiet", 8);

      // Non-SMAQA operations are ignored.
      valid = 1'b1;
      op    = MUL;
      quiet("nonsmaqa_quiet", 6);
      check("nonsmaqa_ready", 32'(ready), 32'd1);
      op    = ADD;
      @(negedge clk);
      check("nonsmaqa_ready2", 32'(ready), 32'd1);
      valid = 1'b0;
      quiet("nonsmaqa_quiet2", 6);

      // Randomized operations, mixing back-to-back and idle gaps.
      for (int t = 0; t < 40; t++) begin
         a  = $urandom;
         b  = $urandom;
         c  = $urandom;
         id = TRANS_ID_BITS'($urandom_range(0, (1 << TRANS_ID_BITS) - 1));
         send(a, b, c, id);
         expect_result("rand", ref_smaqa(a, b, c), id);
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clk);
            check("rand_pulse_end", 32'(vout), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/smaqa_iter_unit.md
# smaqa_iter_unit

Iterative, area-reduced SMAQA functional unit. It is the responder on the multiplier-style issue handshake: it accepts a SMAQA operation with operands rs1, rs2 and rd, and returns `rd + Σ sext(rs1.byte[i]) * sext(rs2.byte[i])`. It reuses a single 8x8 signed multiplier over four cycles and sits beside `multiplier` in the execute stage, on FPGA builds where DSP count matters.

## Interface
- `CVA6Cfg`, default `cva6_config_pkg::cva6_cfg`: extended CVA6 configuration. Only `riscv::XLEN == 32` is supported; an elaboration-time assertion enforces this.
- `clk_i`  in  1  clock, single clock domain.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  kills any in-flight operation.
- `trans_id_i`  in  `TRANS_ID_BITS`  scoreboard transaction id.
- `valid_i`  in  1  request valid.
- `operation_i`  in  `fu_op`  operation. Only `SMAQA` is accepted.
- `operand_a_i`  in  32  rs1 (4 signed bytes).
- `operand_b_i`  in  32  rs2 (4 signed bytes).
- `operand_c_i`  in  32  rd accumulator input.
- `ready_o`  out  1  unit can accept a request this cycle.
- `valid_o`  out  1  result valid, a single-cycle pulse.
- `result_o`  out  32  accumulated result.
- `trans_id_o`  out  `TRANS_ID_BITS`  id of the returned result.

## Operation
- Accept: `valid_i && ready_o && operation_i == SMAQA` at a rising edge. On accept, latch a, b, trans_id; set acc ← c and lane counter ← 0.
- A request with `valid_i` and an operation other than SMAQA is ignored. There is no response and no state change.
- FSM states:
  - IDLE → BUSY on accept.
  - BUSY: each cycle, acc ← acc + sext(a[8i+7:8i]) * sext(b[8i+7:8i]) for i = counter, then counter++. When counter == 3 and that lane is processed, go to DONE.
  - DONE: `valid_o` = 1. If a new accept occurs in the same cycle, go to BUSY; otherwise go to IDLE.
- Arithmetic:
  - Each 16-bit signed product is sign-extended to 32 bits.
  - acc is 32 bits, wrapping modulo 2^32, with no saturation and no overflow flag.
- `ready_o` = 1 in IDLE and DONE, 0 in BUSY and while `flush_i` is high.
- There is no output back-pressure; the writeback port always consumes `valid_o`.
- `flush_i` in BUSY or DONE:
  - next state is IDLE;
  - `valid_o` is forced to 0 in that same cycle (combinational gate);
  - a request presented during flush is not accepted.
- Reset (`rst_ni` = 0 at an edge, including mid-operation): state IDLE, acc 0, counter 0, latched id 0. Any in-flight result is dropped.
- Output reset values: `valid_o` 0, `result_o` 0, `trans_id_o` 0, `ready_o` 1 from the first cycle after reset.
- `result_o` and `trans_id_o` hold their last value outside DONE.

## Timing
- Accept at edge k. Lanes 0..3 are accumulated at edges k+1..k+4. `valid_o` is high in the cycle after edge k+4: latency is 5 cycles from accept.
- Throughput is one op per 5 cycles, including back-to-back accept in DONE. An accept in DONE overlaps the result cycle.
- `ready_o` and the `valid_o` flush gate are the only combinational outputs. `result_o` and `trans_id_o` are registered.

## Structure
- The `smaqa_state_e` enum (IDLE, BUSY, DONE) belongs in `ariane_pkg`, next to the `SMAQA` fu_op.
- The lane index width (2 bits) is also a constant in `ariane_pkg`.
- One sub-module, `smaqa_lane_mac`, is natural: a combinational 8x8 signed multiply plus 32-bit add, `acc_o = acc_i + sext(a_i * b_i)`.

## Test plan
- a=0x01020304, b=0x05060708, c=0x00000009, id=3 → after 5 cycles, one-cycle `valid_o`, result 0x0000004F, `trans_id_o` 3.
- a=0xFFFFFFFF, b=0x01010101, c=0 → 0xFFFFFFFC. a=b=0x80808080, c=0 → 0x00010000.
- Wrap: a=0x00000001, b=0x00000001, c=0x7FFFFFFF → 0x80000000.
- Back-to-back: second request, id 5, held valid from the DONE cycle of the first → accepted in DONE. Second result arrives exactly 5 cycles later. `ready_o` is low for the 4 BUSY cycles in between.
- `flush_i` pulsed 2 cycles after accept → no `valid_o` ever, IDLE next cycle. A new request after flush gives a correct result.
- Reset asserted mid-BUSY → outputs 0, `ready_o` 1 after release. A non-SMAQA `operation_i` with `valid_i` → never accepted, no `valid_o`.
